// File: rtl/rc4_pkg.sv
// Shared types and default constants for the RC4 key-search dispatcher.
package rc4_pkg;

    localparam int unsigned RC4_KEY_WIDTH = 24;
    localparam logic [RC4_KEY_WIDTH-1:0] RC4_KEY_MAX = 24'h3FFFFF;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        DRAIN,
        FOUND,
        EXHAUSTED
    } state_e;

endpackage

// File: rtl/rc4_prio_enc.sv
// Lowest-set-bit priority encoder with a valid flag; bit 0 has highest priority.
module rc4_prio_enc #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rc4_key_dispatch.sv
// Hands out sequential RC4 keys to a pool of cracking cores and collects the
// pass/fail results until a key passes or the key space is used up.
module rc4_key_dispatch
    import rc4_pkg::*;
#(
    parameter int unsigned          NUM_CORES = 4,
    parameter int unsigned          KEY_WIDTH = RC4_KEY_WIDTH,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX   = RC4_KEY_MAX
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    output logic [NUM_CORES-1:0]           core_start,
    output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
    input  logic [NUM_CORES-1:0]           core_done,
    input  logic [NUM_CORES-1:0]           core_success,
    output logic                           core_abort,
    output logic                           busy,
    output logic                           found,
    output logic                           exhausted,
    output logic [KEY_WIDTH-1:0]           found_key,
    output logic [KEY_WIDTH:0]             keys_tried
);

    localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [KEY_WIDTH:0] KEY_LAST = {1'b0, KEY_MAX};

    state_e                 state_q, state_d;
    logic [KEY_WIDTH:0]     next_key_q, next_key_d;
    logic [KEY_WIDTH:0]     keys_tried_q, keys_tried_d;
    logic [NUM_CORES-1:0]   pending_q, pending_d;
    logic [NUM_CORES-1:0]   active_q, active_d;
    logic [NUM_CORES-1:0]   core_start_q, core_start_d;
    logic [KEY_WIDTH-1:0]   key_q [NUM_CORES];
    logic [KEY_WIDTH-1:0]   key_d [NUM_CORES];
    logic [IDX_W-1:0]       launch_idx_q, launch_idx_d;
    logic                   core_abort_q, core_abort_d;
    logic                   busy_q, busy_d;
    logic                   found_q, found_d;
    logic                   exhausted_q, exhausted_d;
    logic [KEY_WIDTH-1:0]   found_key_q, found_key_d;

    logic                   searching;
    logic                   key_left;
    logic [NUM_CORES-1:0]   fail_vec;
    logic [NUM_CORES-1:0]   succ_vec;
    logic [NUM_CORES-1:0]   ready_vec;
    logic [IDX_W-1:0]       disp_idx;
    logic                   disp_valid;
    logic [IDX_W-1:0]       succ_idx;
    logic                   succ_valid;
    logic [KEY_WIDTH:0]     fail_count;
    logic [KEY_WIDTH-1:0]   succ_key;
    logic                   issue_en;
    logic [IDX_W-1:0]       issue_idx;

    // Done pulses only matter while a search is in flight.
    assign searching = (state_q == LAUNCH) || (state_q == RUN) || (state_q == DRAIN);
    assign key_left  = (next_key_q <= KEY_LAST);
    assign fail_vec  = searching ? (core_done & ~core_success) : '0;
    assign succ_vec  = searching ? (core_done & core_success) : '0;
    assign ready_vec = pending_q | fail_vec;

    rc4_prio_enc #(
        .WIDTH (NUM_CORES),
        .IDX_W (IDX_W)
    ) u_disp_enc (
        .req_i   (ready_vec),
        .idx_o   (disp_idx),
        .valid_o (disp_valid)
    );

    rc4_prio_enc #(
        .WIDTH (NUM_CORES),
        .IDX_W (IDX_W)
    ) u_succ_enc (
        .req_i   (succ_vec),
        .idx_o   (succ_idx),
        .valid_o (succ_valid)
    );

    always_comb begin
        fail_count = '0;
        succ_key   = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            fail_count = fail_count + {{KEY_WIDTH{1'b0}}, fail_vec[c]};
            if (IDX_W'(c) == succ_idx) begin
                succ_key = key_q[c];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        next_key_d   = next_key_q;
        keys_tried_d = keys_tried_q + fail_count;
        pending_d    = ready_vec;
        active_d     = active_q & ~core_done;
        core_start_d = '0;
        key_d        = key_q;
        launch_idx_d = launch_idx_q;
        core_abort_d = 1'b0;
        found_d      = found_q;
        exhausted_d  = exhausted_q;
        found_key_d  = found_key_q;
        issue_en     = 1'b0;
        issue_idx    = '0;

        case (state_q)
            IDLE, FOUND, EXHAUSTED: begin
                if (start) begin
                    state_d      = LAUNCH;
                    next_key_d   = '0;
                    keys_tried_d = '0;
                    found_d      = 1'b0;
                    exhausted_d  = 1'b0;
                    pending_d    = '0;
                    active_d     = '0;
                    launch_idx_d = '0;
                end
            end
            LAUNCH, RUN: begin
                if (!key_left) begin
                    state_d = DRAIN;
                end else if (state_q == LAUNCH) begin
                    issue_en  = 1'b1;
                    issue_idx = launch_idx_q;
                    if (launch_idx_q == IDX_W'(NUM_CORES - 1)) begin
                        state_d = RUN;
                    end else begin
                        launch_idx_d = launch_idx_q + 1'b1;
                    end
                end else if (disp_valid) begin
                    issue_en  = 1'b1;
                    issue_idx = disp_idx;
                end
            end
            DRAIN: begin
                if ((active_q & ~core_done) == '0) begin
                    state_d     = EXHAUSTED;
                    exhausted_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A passing key outranks everything else decided this cycle.
        if (succ_valid) begin
            state_d      = FOUND;
            found_d      = 1'b1;
            found_key_d  = succ_key;
            core_abort_d = 1'b1;
            exhausted_d  = 1'b0;
            issue_en     = 1'b0;
        end

        // Issuing only happens while key_left holds, so next_key tops out at KEY_MAX+1.
        if (issue_en) begin
            next_key_d = next_key_q + 1'b1;
            for (int c = 0; c < NUM_CORES; c++) begin
                if (IDX_W'(c) == issue_idx) begin
                    core_start_d[c] = 1'b1;
                    key_d[c]        = next_key_q[KEY_WIDTH-1:0];
                    active_d[c]     = 1'b1;
                    pending_d[c]    = 1'b0;
                end
            end
        end

        busy_d = (state_d == LAUNCH) || (state_d == RUN) || (state_d == DRAIN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            next_key_q   <= '0;
            keys_tried_q <= '0;
            pending_q    <= '0;
            active_q     <= '0;
            core_start_q <= '0;
            launch_idx_q <= '0;
            core_abort_q <= 1'b0;
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            found_key_q  <= '0;
            for (int c = 0; c < NUM_CORES; c++) begin
                key_q[c] <= '0;
            end
        end else begin
            state_q      <= state_d;
            next_key_q   <= next_key_d;
            keys_tried_q <= keys_tried_d;
            pending_q    <= pending_d;
            active_q     <= active_d;
            core_start_q <= core_start_d;
            launch_idx_q <= launch_idx_d;
            core_abort_q <= core_abort_d;
            busy_q       <= busy_d;
            found_q      <= found_d;
            exhausted_q  <= exhausted_d;
            found_key_q  <= found_key_d;
            for (int c = 0; c < NUM_CORES; c++) begin
                key_q[c] <= key_d[c];
            end
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_key_out
        assign core_key[g*KEY_WIDTH +: KEY_WIDTH] = key_q[g];
    end

    assign core_start = core_start_q;
    assign core_abort = core_abort_q;
    assign busy       = busy_q;
    assign found      = found_q;
    assign exhausted  = exhausted_q;
    assign found_key  = found_key_q;
    assign keys_tried = keys_tried_q;

endmodule

// File: tb/tb_rc4_key_dispatch.sv
// Directed bench for rc4_key_dispatch: three instances cover the default
// search space, a tiny KEY_MAX=9 space and a single-core KEY_MAX=0 space.
module tb_rc4_key_dispatch;

    typedef struct {
        logic        st;
        logic [3:0]  done;
        logic [3:0]  succ;
        logic [3:0]  expCs;
        logic [23:0] expKey;
        logic        expBusy;
        logic        expFound;
        logic        expExh;
        logic        expAbort;
        logic [24:0] expTried;
    } vecT;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic        startA = 1'b0, startB = 1'b0, startC = 1'b0;
    logic [3:0]  doneA = '0, succA = '0, doneB = '0, succB = '0;
    logic [0:0]  doneC = '0, succC = '0;
    logic [3:0]  csA, csB;
    logic [0:0]  csC;
    logic [95:0] keyA, keyB;
    logic [23:0] keyC;
    logic        abortA, busyA, foundA, exhA;
    logic        abortB, busyB, foundB, exhB;
    logic        abortC, busyC, foundC, exhC;
    logic [23:0] fkA, fkB, fkC;
    logic [24:0] triedA, triedB, triedC;

    int checks = 0;
    int errors = 0;
    vecT tableB [16];

    always #5 clk = ~clk;

    rc4_key_dispatch #(.NUM_CORES(4)) dutA (
        .clk(clk), .reset_n(reset_n), .start(startA),
        .core_start(csA), .core_key(keyA), .core_done(doneA), .core_success(succA),
        .core_abort(abortA), .busy(busyA), .found(foundA), .exhausted(exhA),
        .found_key(fkA), .keys_tried(triedA)
    );

    rc4_key_dispatch #(.NUM_CORES(4), .KEY_WIDTH(24), .KEY_MAX(24'd9)) dutB (
        .clk(clk), .reset_n(reset_n), .start(startB),
        .core_start(csB), .core_key(keyB), .core_done(doneB), .core_success(succB),
        .core_abort(abortB), .busy(busyB), .found(foundB), .exhausted(exhB),
        .found_key(fkB), .keys_tried(triedB)
    );

    rc4_key_dispatch #(.NUM_CORES(1), .KEY_WIDTH(24), .KEY_MAX(24'd0)) dutC (
        .clk(clk), .reset_n(reset_n), .start(startC),
        .core_start(csC), .core_key(keyC), .core_done(doneC), .core_success(succC),
        .core_abort(abortC), .busy(busyC), .found(foundC), .exhausted(exhC),
        .found_key(fkC), .keys_tried(triedC)
    );

    function automatic vecT mk(input int st, input int done, input int succ,
                               input int cs, input int key, input int bz,
                               input int fd, input int ex, input int ab, input int tried);
        vecT v;
        v.st       = 1'(st);
        v.done     = 4'(done);
        v.succ     = 4'(succ);
        v.expCs    = 4'(cs);
        v.expKey   = 24'(key);
        v.expBusy  = 1'(bz);
        v.expFound = 1'(fd);
        v.expExh   = 1'(ex);
        v.expAbort = 1'(ab);
        v.expTried = 25'(tried);
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs are held for exactly one rising edge, then outputs are sampled 1ns later.
    task automatic applyStimulus(input int sel, input logic st, input logic [3:0] done, input logic [3:0] succ);
        case (sel)
            0: begin startA = st; doneA = done; succA = succ; end
            1: begin startB = st; doneB = done; succB = succ; end
            default: begin startC = st; doneC = done[0:0]; succC = succ[0:0]; end
        endcase
        @(posedge clk);
        #1;
        startA = 1'b0; doneA = '0; succA = '0;
        startB = 1'b0; doneB = '0; succB = '0;
        startC = 1'b0; doneC = '0; succC = '0;
    endtask

    task automatic checkOutput(input string name, input int sel, input vecT v);
        logic [3:0]  cs;
        logic [95:0] kf;
        logic        bz, fd, ex, ab;
        logic [24:0] tr;
        case (sel)
            0: begin cs = csA; kf = keyA; bz = busyA; fd = foundA; ex = exhA; ab = abortA; tr = triedA; end
            1: begin cs = csB; kf = keyB; bz = busyB; fd = foundB; ex = exhB; ab = abortB; tr = triedB; end
            default: begin
                cs = {3'b000, csC}; kf = {72'd0, keyC};
                bz = busyC; fd = foundC; ex = exhC; ab = abortC; tr = triedC;
            end
        endcase
        checkVal({name, " core_start"}, 32'(cs), 32'(v.expCs));
        if (v.expCs != 4'd0) begin
            for (int i = 0; i < 4; i++) begin
                if (v.expCs[i]) begin
                    checkVal({name, " core_key"}, 32'(kf[i*24 +: 24]), 32'(v.expKey));
                end
            end
        end
        checkVal({name, " busy"}, 32'(bz), 32'(v.expBusy));
        checkVal({name, " found"}, 32'(fd), 32'(v.expFound));
        checkVal({name, " exhausted"}, 32'(ex), 32'(v.expExh));
        checkVal({name, " core_abort"}, 32'(ab), 32'(v.expAbort));
        checkVal({name, " keys_tried"}, 32'(tr), 32'(v.expTried));
    endtask

    task automatic runVec(input string name, input int sel, input vecT v);
        applyStimulus(sel, v.st, v.done, v.succ);
        checkOutput(name, sel, v);
    endtask

    initial begin
        // KEY_MAX=9 with every core failing: keys 0..9 each issued once, then drain.
        tableB[0]  = mk(1, 0,       0, 0,       0, 1, 0, 0, 0, 0);
        tableB[1]  = mk(0, 0,       0, 4'b0001, 0, 1, 0, 0, 0, 0);
        tableB[2]  = mk(0, 0,       0, 4'b0010, 1, 1, 0, 0, 0, 0);
        tableB[3]  = mk(0, 0,       0, 4'b0100, 2, 1, 0, 0, 0, 0);
        tableB[4]  = mk(0, 0,       0, 4'b1000, 3, 1, 0, 0, 0, 0);
        tableB[5]  = mk(0, 4'b1111, 0, 4'b0001, 4, 1, 0, 0, 0, 4);
        tableB[6]  = mk(0, 0,       0, 4'b0010, 5, 1, 0, 0, 0, 4);
        tableB[7]  = mk(0, 0,       0, 4'b0100, 6, 1, 0, 0, 0, 4);
        tableB[8]  = mk(0, 0,       0, 4'b1000, 7, 1, 0, 0, 0, 4);
        tableB[9]  = mk(0, 4'b0011, 0, 4'b0001, 8, 1, 0, 0, 0, 6);
        tableB[10] = mk(0, 0,       0, 4'b0010, 9, 1, 0, 0, 0, 6);
        tableB[11] = mk(0, 0,       0, 0,       0, 1, 0, 0, 0, 6);
        tableB[12] = mk(0, 4'b1100, 0, 0,       0, 1, 0, 0, 0, 8);
        tableB[13] = mk(0, 4'b0001, 0, 0,       0, 1, 0, 0, 0, 9);
        tableB[14] = mk(0, 4'b0010, 0, 0,       0, 0, 0, 1, 0, 10);
        tableB[15] = mk(0, 4'b1111, 0, 0,       0, 0, 0, 1, 0, 10);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetA", 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        checkVal("resetA key", 32'(keyA != '0), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Initial launch: cores 0..3 get keys 0..3 on consecutive cycles.
        runVec("A start", 0, mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        for (int c = 0; c < 4; c++) begin
            runVec($sformatf("A launch%0d", c), 0, mk(0, 0, 0, 1 << c, c, 1, 0, 0, 0, 0));
        end
        runVec("A run idle", 0, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

        // Cores 1 and 3 fail together and are refilled one per cycle.
        runVec("A dual fail", 0, mk(0, 4'b1010, 0, 4'b0010, 4, 1, 0, 0, 0, 2));
        runVec("A dual second", 0, mk(0, 0, 0, 4'b1000, 5, 1, 0, 0, 0, 2));
        runVec("A quiet", 0, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2));

        // Core 2 keeps failing until it holds 0xA2; the first start is ignored while busy.
        for (int k = 0; k <= 156; k++) begin
            runVec($sformatf("A core2 k%0d", k), 0,
                   mk((k == 0) ? 1 : 0, 4'b0100, 0, 4'b0100, 6 + k, 1, 0, 0, 0, 3 + k));
        end
        runVec("A success", 0, mk(0, 4'b0101, 4'b0100, 0, 0, 0, 1, 0, 1, 160));
        checkVal("A found_key", 32'(fkA), 32'h0000A2);
        runVec("A after found", 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 160));
        runVec("A done ignored", 0, mk(0, 4'b1111, 0, 0, 0, 0, 1, 0, 0, 160));

        // Restart, get into RUN, then pull reset between clock edges.
        runVec("A restart", 0, mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        for (int c = 0; c < 4; c++) begin
            runVec($sformatf("A relaunch%0d", c), 0, mk(0, 0, 0, 1 << c, c, 1, 0, 0, 0, 0));
        end
        runVec("A rerun", 0, mk(0, 4'b0001, 0, 4'b0001, 4, 1, 0, 0, 0, 1));
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("A async reset", 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        checkVal("A reset key", 32'(keyA != '0), 32'd0);
        checkVal("A reset found_key", 32'(fkA), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        runVec("A post-reset start", 0, mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        runVec("A post-reset launch0", 0, mk(0, 0, 0, 4'b0001, 0, 1, 0, 0, 0, 0));
        runVec("A post-reset launch1", 0, mk(0, 0, 0, 4'b0010, 1, 1, 0, 0, 0, 0));

        for (int i = 0; i < 16; i++) begin
            runVec($sformatf("B step%0d", i), 1, tableB[i]);
        end

        // Single core, single key: fail exhausts, then a retry that passes.
        runVec("C start", 2, mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        runVec("C launch", 2, mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        runVec("C drain", 2, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        runVec("C fail", 2, mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 1));
        runVec("C restart", 2, mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        runVec("C relaunch", 2, mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        runVec("C success", 2, mk(0, 1, 1, 0, 0, 0, 1, 0, 1, 0));
        checkVal("C found_key", 32'(fkC), 32'd0);
        runVec("C after found", 2, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
